// File: rtl/ifetch32_pkg.sv
// Shared types and constants for the ifetch32_seq instruction fetch sequencer.
// Holds the FSM state encoding, the default reset PC and the instruction-field positions.
package ifetch32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // J-type target index and the PC region bits it is concatenated with
  localparam int JIDX_MSB      = 25;
  localparam int JIDX_LSB      = 0;
  localparam int PC_REGION_MSB = 31;
  localparam int PC_REGION_LSB = 28;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ifetch32_seq_pc_next_sel.sv
// Combinational next-PC selection for ifetch32_seq.
// Priority: jr, then jump/jal, then taken branch, then sequential PC+4 (wraps modulo 2^32).
module pc_next_sel
  import ifetch32_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [25:0] i_jidx,
  input  logic [29:0] i_br_word,
  input  logic [31:0] i_jr_addr,
  input  logic        i_branch,
  input  logic        i_nbranch,
  input  logic        i_jmp,
  input  logic        i_jal,
  input  logic        i_jrn,
  input  logic        i_zero,
  output logic [31:0] o_pc_plus_4,
  output logic [31:0] o_next_pc
);

  logic w_taken;

  assign o_pc_plus_4 = i_pc + PC_STEP;
  // Branch and nBranch may both be set; either satisfied condition takes the branch
  assign w_taken     = (i_branch & i_zero) | (i_nbranch & ~i_zero);

  always_comb begin
    o_next_pc = o_pc_plus_4;
    if (i_jrn) begin
      o_next_pc = i_jr_addr;
    end else if (i_jmp | i_jal) begin
      o_next_pc = {o_pc_plus_4[PC_REGION_MSB:PC_REGION_LSB], i_jidx, 2'b00};
    end else if (w_taken) begin
      o_next_pc = {i_br_word, 2'b00};
    end
  end

endmodule

// File: rtl/ifetch32_seq.sv
// Instruction fetch sequencer: fetches one word, holds it for execute, then steps the PC.
// Optional macro IFETCH_ALIGN_CHECK_EN: misaligned next PC sets sticky addr_err and halts.
//
// state | meaning
// IDLE  | one cycle after reset before the first request
// FETCH | imem_req high at PC, waiting for imem_ready
// EXEC  | Instruction valid; next-PC controls sampled when not stalled
// HALT  | misaligned next PC seen; left only through reset
module ifetch32_seq
  import ifetch32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic        instr_valid,
  output logic [31:0] PC_plus_4,
  output logic [31:0] opcplus4,
  input  logic [31:0] Add_Result,
  input  logic [31:0] Read_data_1,
  input  logic        Branch,
  input  logic        nBranch,
  input  logic        Jmp,
  input  logic        Jal,
  input  logic        Jrn,
  input  logic        Zero,
  input  logic        stall_in,
  output logic        addr_err
);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;
  logic        r_req;
  logic [31:0] r_opc;

  logic [31:0] w_pc_plus_4;
  logic [31:0] w_next_raw;
  logic [31:0] w_next_pc;
  logic        w_unused_add;

  // Branch target arrives as a word address; its top two bits fall off the shift
  assign w_unused_add = ^Add_Result[31:30];

  pc_next_sel u_pc_next_sel (
    .i_pc        (r_pc),
    .i_jidx      (r_instr[JIDX_MSB:JIDX_LSB]),
    .i_br_word   (Add_Result[29:0]),
    .i_jr_addr   (Read_data_1),
    .i_branch    (Branch),
    .i_nbranch   (nBranch),
    .i_jmp       (Jmp),
    .i_jal       (Jal),
    .i_jrn       (Jrn),
    .i_zero      (Zero),
    .o_pc_plus_4 (w_pc_plus_4),
    .o_next_pc   (w_next_raw)
  );

`ifdef IFETCH_ALIGN_CHECK_EN
  logic r_addr_err;
  logic w_misaligned;

  assign w_next_pc    = w_next_raw;
  assign w_misaligned = ~is_word_aligned(w_next_raw);
  assign addr_err     = r_addr_err;
`else
  logic w_unused_low;

  assign w_next_pc    = {w_next_raw[31:2], 2'b00};
  assign w_unused_low = ^w_next_raw[1:0];
  assign addr_err     = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
      r_valid <= 1'b0;
      r_req   <= 1'b0;
      r_opc   <= 32'h0;
`ifdef IFETCH_ALIGN_CHECK_EN
      r_addr_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_FETCH;
          r_req   <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ready) begin
            r_instr <= imem_rdata;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!stall_in) begin
            r_valid <= 1'b0;
            if (Jal && !Jrn) begin
              r_opc <= w_pc_plus_4;
            end
`ifdef IFETCH_ALIGN_CHECK_EN
            if (w_misaligned) begin
              r_addr_err <= 1'b1;
              r_req      <= 1'b0;
              r_state    <= ST_HALT;
            end else begin
              r_pc    <= w_next_pc;
              r_req   <= 1'b1;
              r_state <= ST_FETCH;
            end
`else
            r_pc    <= w_next_pc;
            r_req   <= 1'b1;
            r_state <= ST_FETCH;
`endif
          end
        end
        ST_HALT: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign Instruction = r_instr;
  assign instr_valid = r_valid;
  assign PC_plus_4   = w_pc_plus_4;
  assign opcplus4    = r_opc;

endmodule

// File: tb/tb_ifetch32_seq.sv
// Self-checking bench for ifetch32_seq: expected fetch addresses are queued when the
// next-PC controls are driven and popped when the DUT raises its next request.
module tb_ifetch32_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] Instruction;
  logic        instr_valid;
  logic [31:0] PC_plus_4;
  logic [31:0] opcplus4;
  logic [31:0] Add_Result = 32'h0;
  logic [31:0] Read_data_1 = 32'h0;
  logic        Branch = 1'b0, nBranch = 1'b0, Jmp = 1'b0, Jal = 1'b0, Jrn = 1'b0, Zero = 1'b0;
  logic        stall_in = 1'b0;
  logic        addr_err;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] exp_q[$];
  int          waited;

  ifetch32_seq dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .Instruction (Instruction),
    .instr_valid (instr_valid),
    .PC_plus_4   (PC_plus_4),
    .opcplus4    (opcplus4),
    .Add_Result  (Add_Result),
    .Read_data_1 (Read_data_1),
    .Branch      (Branch),
    .nBranch     (nBranch),
    .Jmp         (Jmp),
    .Jal         (Jal),
    .Jrn         (Jrn),
    .Zero        (Zero),
    .stall_in    (stall_in),
    .addr_err    (addr_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_ctl();
    Branch = 1'b0; nBranch = 1'b0; Jmp = 1'b0; Jal = 1'b0; Jrn = 1'b0; Zero = 1'b0;
    Add_Result = 32'h0; Read_data_1 = 32'h0; stall_in = 1'b0;
  endtask

  // Advance past the EXEC exit (or IDLE), then wait bounded for the next request.
  task automatic wait_req(input string tag, output int n_wait);
    logic [31:0] e;
    n_wait = 0;
    tick();
    clr_ctl();
    while (imem_req !== 1'b1 && n_wait < 20) begin
      tick();
      n_wait++;
    end
    chk({tag, "_req"}, {31'h0, imem_req}, 32'h1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_depth"}, 32'(exp_q.size()), 32'h1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_addr"}, imem_addr, e);
    end
  endtask

  task automatic give_instr(input string tag, input logic [31:0] rdata);
    imem_ready = 1'b1;
    imem_rdata = rdata;
    tick();
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    chk({tag, "_valid"}, {31'h0, instr_valid}, 32'h1);
    chk({tag, "_instr"}, Instruction, rdata);
    chk({tag, "_req_low"}, {31'h0, imem_req}, 32'h0);
  endtask

  initial begin
    clr_ctl();
    tick();
    tick();
    chk("rst_req",   {31'h0, imem_req},    32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", Instruction,          32'h0);
    chk("rst_opc",   opcplus4,             32'h0);
    chk("rst_err",   {31'h0, addr_err},    32'h0);
    chk("rst_addr",  imem_addr,            32'h0);
    reset = 1'b0;

    // sequential fetches
    exp_q.push_back(32'h0);
    wait_req("seq0", waited);
    chk("idle_to_fetch", 32'(waited), 32'h0);
    give_instr("seq0", 32'h0000_0013);
    chk("seq0_pc4", PC_plus_4, 32'h4);
    exp_q.push_back(32'h4);
    wait_req("seq1", waited);
    chk("b2b_fetch", 32'(waited), 32'h0);
    give_instr("seq1", 32'h0000_0013);
    exp_q.push_back(32'h8);
    wait_req("seq2", waited);
    give_instr("seq2", 32'h0800_0010);

    // jump to 0x40
    Jmp = 1'b1;
    exp_q.push_back(32'h40);
    wait_req("jmp", waited);
    give_instr("jmp", 32'h1000_0000);

    // taken branch
    Branch = 1'b1; Zero = 1'b1; Add_Result = 32'h20;
    exp_q.push_back(32'h80);
    wait_req("beq_t", waited);
    give_instr("beq_t", 32'h1000_0001);

    // branch not taken
    Branch = 1'b1; Zero = 1'b0; Add_Result = 32'h20;
    exp_q.push_back(32'h84);
    wait_req("beq_nt", waited);
    give_instr("beq_nt", 32'h1400_0002);

    // nBranch taken
    nBranch = 1'b1; Zero = 1'b0; Add_Result = 32'h40;
    exp_q.push_back(32'h100);
    wait_req("bne_t", waited);
    give_instr("jal", 32'h0C00_0010);

    // jal link
    Jal = 1'b1;
    exp_q.push_back(32'h40);
    wait_req("jal", waited);
    chk("jal_link", opcplus4, 32'h104);
    give_instr("both_br", 32'h1000_0003);

    // both branch flags, either condition suffices
    Branch = 1'b1; nBranch = 1'b1; Zero = 1'b0; Add_Result = 32'h30;
    exp_q.push_back(32'hC0);
    wait_req("both_br", waited);
    chk("link_hold", opcplus4, 32'h104);
    give_instr("jr", 32'hABCD_0001);

    // jr wins over jmp/jal, with a 3-cycle stall first
    stall_in = 1'b1;
    Jrn = 1'b1; Jmp = 1'b1; Jal = 1'b1; Read_data_1 = 32'h200;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", {31'h0, instr_valid}, 32'h1);
      chk("stall_instr", Instruction, 32'hABCD_0001);
      chk("stall_req",   {31'h0, imem_req}, 32'h0);
      chk("stall_addr",  imem_addr, 32'hC0);
    end
    stall_in = 1'b0;
    exp_q.push_back(32'h200);
    wait_req("jr", waited);
    chk("jr_no_link", opcplus4, 32'h104);
    give_instr("jr_top", 32'h0000_0013);

    // PC wrap at top of address space
    Jrn = 1'b1; Read_data_1 = 32'hFFFF_FFFC;
    exp_q.push_back(32'hFFFF_FFFC);
    wait_req("jr_top", waited);
    give_instr("wrap", 32'h0000_0013);
    chk("wrap_pc4", PC_plus_4, 32'h0);
    exp_q.push_back(32'h0);
    wait_req("wrap", waited);
    give_instr("to300", 32'h0000_0013);

    // reset while a fetch is outstanding
    Jrn = 1'b1; Read_data_1 = 32'h300;
    exp_q.push_back(32'h300);
    wait_req("f300", waited);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("hold_req",  {31'h0, imem_req}, 32'h1);
      chk("hold_addr", imem_addr, 32'h300);
    end
    reset = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    reset = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    chk("frst_req",   {31'h0, imem_req},    32'h0);
    chk("frst_valid", {31'h0, instr_valid}, 32'h0);
    chk("frst_instr", Instruction,          32'h0);
    chk("frst_addr",  imem_addr,            32'h0);
    chk("frst_opc",   opcplus4,             32'h0);
    exp_q.push_back(32'h0);
    wait_req("post_rst", waited);
    give_instr("post_rst", 32'h0000_0011);

    // misaligned jr target
    Jrn = 1'b1; Read_data_1 = 32'h202;
`ifdef IFETCH_ALIGN_CHECK_EN
    tick();
    clr_ctl();
    for (int i = 0; i < 4; i++) begin
      chk("halt_err",   {31'h0, addr_err},    32'h1);
      chk("halt_req",   {31'h0, imem_req},    32'h0);
      chk("halt_valid", {31'h0, instr_valid}, 32'h0);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("halt_rst_err", {31'h0, addr_err}, 32'h0);
    exp_q.push_back(32'h0);
    wait_req("after_halt", waited);
    give_instr("after_halt", 32'h0000_0013);
`else
    exp_q.push_back(32'h200);
    wait_req("misal", waited);
    chk("misal_err", {31'h0, addr_err}, 32'h0);
    give_instr("misal", 32'h0000_0013);
`endif

    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch32_seq.md
IFETCH32_SEQ -- requirements
Module: ifetch32_seq

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address fetched first after reset.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 imem_req  out  1  instruction-memory read request.
REQ-005 imem_addr  out  32  byte address of requested instruction (= PC).
REQ-006 imem_ready  in  1  memory accepted request; imem_rdata valid this cycle.
REQ-007 imem_rdata  in  32  instruction word from memory.
REQ-008 Instruction  out  32  registered instruction presented to decode/execute.
REQ-009 instr_valid  out  1  Instruction is valid and next-PC controls are sampled.
REQ-010 PC_plus_4  out  32  PC+4 of the presented instruction (byte address).
REQ-011 opcplus4  out  32  link address, loaded with PC_plus_4 on a taken Jal.
REQ-012 Add_Result  in  32  branch target as word address (execute stage output).
REQ-013 Read_data_1  in  32  jr target byte address.
REQ-014 Branch, nBranch, Jmp, Jal, Jrn, Zero  in  1 each  control/execute flags.
REQ-015 stall_in  in  1  downstream hold; freezes current instruction.
REQ-016 addr_err  out  1  misaligned next-PC flag (see Configuration).

Function
REQ-017 FSM states SHALL be IDLE, FETCH, EXEC, HALT; IDLE -> FETCH unconditionally after one cycle.
REQ-018 FETCH: imem_req=1, imem_addr=PC; on imem_ready, Instruction<=imem_rdata, go EXEC; else stay, address stable.
REQ-019 Latency: imem_ready in cycle N -> instr_valid=1 in cycle N+1.
REQ-020 EXEC: instr_valid=1; stall_in=1 holds state, Instruction, PC, all outputs; imem_req=0.
REQ-021 EXEC with stall_in=0: PC<=next PC, state->FETCH; instr_valid drops next cycle.
REQ-022 Next-PC priority: Jrn -> Read_data_1; else Jmp|Jal -> {PC_plus_4[31:28],Instruction[25:0],2'b00}; else (Branch&Zero)|(nBranch&~Zero) -> {Add_Result[29:0],2'b00}; else PC_plus_4.
REQ-023 PC_plus_4 = PC+4 modulo 2^32; PC 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-024 opcplus4 updates only on EXEC exit with Jal=1 and Jrn=0; otherwise holds.
REQ-025 Branch and nBranch both set: either condition taken suffices.
REQ-026 imem_req SHALL be 0 in IDLE, EXEC, HALT.

Reset
REQ-027 reset SHALL force state=IDLE, PC=RESET_PC, Instruction=0, instr_valid=0, imem_req=0, opcplus4=0, addr_err=0, from the following edge.
REQ-028 reset during FETCH SHALL abandon the request; imem_ready in that same cycle is ignored.

Configuration
REQ-029 Macro IFETCH_ALIGN_CHECK_EN defined: next PC with bits[1:0]!=0 SHALL set addr_err (sticky) and enter HALT; HALT exits only on reset.
REQ-030 Macro undefined: next PC bits[1:0] forced to 2'b00, addr_err tied 0, HALT unreachable.

Structure
REQ-031 Package ifetch32_pkg SHALL hold the state enum, default RESET_PC, instruction-field position constants.
REQ-032 Combinational sub-module pc_next_sel SHALL implement REQ-022/023 next-PC selection; the FSM and registers stay in ifetch32_seq.

Verification
REQ-033 Reset, RESET_PC=0, imem_ready=1 always -> imem_addr 0,4,8 on successive FETCHs; instr_valid every 2nd cycle after IDLE.
REQ-034 PC=0x40, Branch=1, Zero=1, Add_Result=0x20 -> next imem_addr=0x80; Zero=0 -> 0x44.
REQ-035 PC=0x100, Instruction=0x0C00_0010, Jal=1 -> next imem_addr=0x40, opcplus4=0x104.
REQ-036 Jrn=1, Jmp=1, Read_data_1=0x200 -> next imem_addr=0x200 (Jrn wins); stall_in=1 for 3 cycles holds instr_valid=1 and Instruction.
REQ-037 imem_ready low 5 cycles -> imem_req/imem_addr stable; reset asserted in cycle 3 -> state IDLE, PC=RESET_PC, rdata discarded.
REQ-038 With IFETCH_ALIGN_CHECK_EN, Jrn=1, Read_data_1=0x202 -> addr_err=1, imem_req=0 until reset; without macro -> imem_addr=0x200.
